// File: rtl/sequenciador_multiciclo.sv
// Multicycle control sequencer for the 3-bit-opcode CPU.
// The control lines are a combinational decode of the registered state, plus a few
// Mealy terms (MemPronta, Zero). The sequencer also counts retired instructions.
module sequenciador_multiciclo #(
    parameter int unsigned ESPERA_MAX = 16,
    parameter int unsigned CONT_W     = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [2:0]        Opcode,
    input  logic              Zero,
    input  logic              MemPronta,
    output logic [1:0]        ULAOp,
    output logic [1:0]        ULAFonte,
    output logic              RegFonte,
    output logic              SelDest,
    output logic              Beqz,
    output logic              Ji,
    output logic              LerMem,
    output logic              EscMem,
    output logic              EscIR,
    output logic              EscReg,
    output logic              EscPC,
    output logic              Ocupado,
    output logic              Parado,
    output logic              Erro,
    output logic [CONT_W-1:0] InstrCont
);

    localparam int unsigned ESPERA_W = $clog2(ESPERA_MAX + 1);
    localparam logic [ESPERA_W-1:0] ESPERA_ULT = ESPERA_W'(ESPERA_MAX - 1);

    localparam logic [2:0] OP_R     = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_BEQZ  = 3'b011;
    localparam logic [2:0] OP_IMM   = 3'b100;
    localparam logic [2:0] OP_JUMP  = 3'b101;
    localparam logic [2:0] OP_110   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [3:0] {
        INICIO, BUSCA, DECOD, EXEC, MEM, ESCRITA, SALTO, DESVIO, PARADO, ERRO
    } estado_t;

    estado_t             state;
    estado_t             nextState;
    logic                retire;
    logic [ESPERA_W-1:0] waitCnt;
    logic                timeout;

    // Last allowed memory-wait cycle elapsed without ready
    assign timeout = !MemPronta && (waitCnt == ESPERA_ULT);

    // State register, memory wait counter and saturating retired counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= INICIO;
            waitCnt   <= '0;
            InstrCont <= '0;
        end else begin
            state <= nextState;
            if (nextState != state) begin
                waitCnt <= '0;
            end else if ((state == BUSCA || state == MEM) && !MemPronta) begin
                waitCnt <= waitCnt + ESPERA_W'(1);
            end
            if (retire && (InstrCont != '1)) begin
                InstrCont <= InstrCont + CONT_W'(1);
            end
        end
    end

    // Next-state and control-line decode
    always_comb begin
        nextState = state;
        retire    = 1'b0;
        ULAOp     = 2'b00;
        ULAFonte  = 2'b00;
        RegFonte  = 1'b0;
        SelDest   = 1'b0;
        Beqz      = 1'b0;
        Ji        = 1'b0;
        LerMem    = 1'b0;
        EscMem    = 1'b0;
        EscIR     = 1'b0;
        EscReg    = 1'b0;
        EscPC     = 1'b0;
        Parado    = 1'b0;
        Erro      = 1'b0;
        Ocupado   = !(state == INICIO || state == PARADO || state == ERRO);

        case (state)
            INICIO: nextState = BUSCA;

            BUSCA: begin
                LerMem = 1'b1;
                if (MemPronta) begin
                    EscIR     = 1'b1;
                    EscPC     = 1'b1;
                    nextState = DECOD;
                end else if (timeout) begin
                    nextState = ERRO;
                end
            end

            DECOD: begin
                case (Opcode)
                    OP_HALT: begin
                        nextState = PARADO;
                        retire    = 1'b1;
                    end
                    OP_JUMP: nextState = SALTO;
                    OP_BEQZ: nextState = DESVIO;
                    default: nextState = EXEC;
                endcase
            end

            EXEC: begin
                case (Opcode)
                    OP_R: begin
                        ULAOp     = 2'b10;
                        nextState = ESCRITA;
                    end
                    OP_110: begin
                        ULAOp     = 2'b01;
                        nextState = ESCRITA;
                    end
                    OP_IMM: begin
                        ULAOp     = 2'b11;
                        ULAFonte  = 2'b01;
                        nextState = ESCRITA;
                    end
                    OP_LOAD, OP_STORE: nextState = MEM;
                    default:           nextState = BUSCA;
                endcase
            end

            MEM: begin
                case (Opcode)
                    OP_LOAD: begin
                        LerMem = 1'b1;
                        if (MemPronta) begin
                            nextState = ESCRITA;
                        end else if (timeout) begin
                            nextState = ERRO;
                        end
                    end
                    OP_STORE: begin
                        EscMem  = 1'b1;
                        SelDest = 1'b1;
                        if (MemPronta) begin
                            nextState = BUSCA;
                            retire    = 1'b1;
                        end else if (timeout) begin
                            nextState = ERRO;
                        end
                    end
                    default: nextState = BUSCA;
                endcase
            end

            ESCRITA: begin
                EscReg    = 1'b1;
                retire    = 1'b1;
                nextState = BUSCA;
                case (Opcode)
                    OP_R:    ULAOp = 2'b10;
                    OP_110:  ULAOp = 2'b01;
                    OP_IMM: begin
                        ULAOp    = 2'b11;
                        ULAFonte = 2'b01;
                    end
                    OP_LOAD: RegFonte = 1'b1;
                    default: ;
                endcase
            end

            SALTO: begin
                Ji        = 1'b1;
                EscPC     = 1'b1;
                retire    = 1'b1;
                nextState = BUSCA;
            end

            DESVIO: begin
                Beqz      = 1'b1;
                EscPC     = Zero;
                retire    = 1'b1;
                nextState = BUSCA;
            end

            PARADO: Parado = 1'b1;

            ERRO: Erro = 1'b1;

            default: nextState = INICIO;
        endcase
    end

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Directed bench for the multicycle control sequencer.
module tb_sequenciador_multiciclo;

    logic       Clock;
    logic       Reset;
    logic [2:0] Opcode;
    logic       Zero;
    logic       MemPronta;
    logic [1:0] ULAOp;
    logic [1:0] ULAFonte;
    logic       RegFonte, SelDest, Beqz, Ji, LerMem, EscMem, EscIR, EscReg, EscPC;
    logic       Ocupado, Parado, Erro;
    logic [1:0] InstrCont;

    int checks   = 0;
    int failures = 0;

    sequenciador_multiciclo #(.ESPERA_MAX(4), .CONT_W(2)) dut (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemPronta(MemPronta),
        .ULAOp(ULAOp), .ULAFonte(ULAFonte), .RegFonte(RegFonte), .SelDest(SelDest),
        .Beqz(Beqz), .Ji(Ji), .LerMem(LerMem), .EscMem(EscMem), .EscIR(EscIR),
        .EscReg(EscReg), .EscPC(EscPC), .Ocupado(Ocupado), .Parado(Parado), .Erro(Erro),
        .InstrCont(InstrCont)
    );

    // Packed view of every control line
    logic [15:0] obs;
    assign obs = {ULAOp, ULAFonte, RegFonte, SelDest, Beqz, Ji, LerMem, EscMem,
                  EscIR, EscReg, EscPC, Ocupado, Parado, Erro};

    localparam logic [15:0] E_ERRO = 16'h0001;
    localparam logic [15:0] E_PAR  = 16'h0002;
    localparam logic [15:0] E_OCU  = 16'h0004;
    localparam logic [15:0] E_PC   = 16'h0008;
    localparam logic [15:0] E_REG  = 16'h0010;
    localparam logic [15:0] E_IR   = 16'h0020;
    localparam logic [15:0] E_ESCM = 16'h0040;
    localparam logic [15:0] E_LER  = 16'h0080;
    localparam logic [15:0] E_JI   = 16'h0100;
    localparam logic [15:0] E_BQ   = 16'h0200;
    localparam logic [15:0] E_SEL  = 16'h0400;
    localparam logic [15:0] E_RF   = 16'h0800;
    localparam logic [15:0] E_FIMM = 16'h1000;
    localparam logic [15:0] E_OP01 = 16'h4000;
    localparam logic [15:0] E_OP10 = 16'h8000;
    localparam logic [15:0] E_OP11 = 16'hC000;
    localparam logic [15:0] E_BUSCA = E_LER | E_IR | E_PC | E_OCU;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one cycle, then apply this cycle's inputs and let decode settle
    task automatic step(input logic [2:0] op, input logic mp, input logic z);
        @(posedge Clock);
        #1;
        Opcode    = op;
        MemPronta = mp;
        Zero      = z;
        #1;
    endtask

    // Pulse reset for one edge; the sequencer is left in INICIO
    task automatic doReset();
        Reset = 1'b1;
        step(3'b000, 1'b0, 1'b0);
        Reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(3'b000, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0);
        checks++;
        if (obs !== 16'h0000) begin
            failures++;
            $display("FAIL reset_outputs obs=%h exp=%h", obs, 16'h0000);
        end
        checks++;
        if (InstrCont !== 2'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", InstrCont);
        end
        Reset = 1'b0;
        #1;
        step(3'b000, 1'b1, 1'b0);
        checks++;
        if (obs !== E_BUSCA) begin
            failures++;
            $display("FAIL reset_to_busca obs=%h exp=%h", obs, E_BUSCA);
        end
    endtask

    // 000, 110 and 100 back to back; ALU ops held from EXEC through ESCRITA
    task automatic test_alu();
        logic [2:0]  ops [3];
        logic [15:0] eop [3];
        ops = '{3'b000, 3'b110, 3'b100};
        eop = '{E_OP10, E_OP01, E_OP11 | E_FIMM};
        doReset();
        for (int k = 0; k < 3; k++) begin
            step(ops[k], 1'b1, 1'b0);
            checks++;
            if (obs !== E_BUSCA || InstrCont !== 2'(k)) begin
                failures++;
                $display("FAIL alu_busca k=%0d obs=%h exp=%h cnt=%0d exp=%0d", k, obs, E_BUSCA, InstrCont, k);
            end
            step(ops[k], 1'b1, 1'b0);
            checks++;
            if (obs !== E_OCU) begin
                failures++;
                $display("FAIL alu_decod k=%0d obs=%h exp=%h", k, obs, E_OCU);
            end
            step(ops[k], 1'b1, 1'b0);
            checks++;
            if (obs !== (eop[k] | E_OCU)) begin
                failures++;
                $display("FAIL alu_exec k=%0d obs=%h exp=%h", k, obs, eop[k] | E_OCU);
            end
            step(ops[k], 1'b1, 1'b0);
            checks++;
            if (obs !== (eop[k] | E_REG | E_OCU) || InstrCont !== 2'(k)) begin
                failures++;
                $display("FAIL alu_escrita k=%0d obs=%h exp=%h cnt=%0d", k, obs, eop[k] | E_REG | E_OCU, InstrCont);
            end
        end
        step(3'b000, 1'b1, 1'b0);
        checks++;
        if (InstrCont !== 2'd3) begin
            failures++;
            $display("FAIL alu_count got=%0d exp=3", InstrCont);
        end
    endtask

    // Load with MemPronta low for 3 MEM cycles, ready on the 4th (last allowed)
    task automatic test_load();
        logic        mp  [9];
        logic [15:0] exp [9];
        mp  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp = '{E_BUSCA, E_OCU, E_OCU, E_LER | E_OCU, E_LER | E_OCU, E_LER | E_OCU,
                E_LER | E_OCU, E_REG | E_RF | E_OCU, E_BUSCA};
        doReset();
        for (int i = 0; i < 9; i++) begin
            step(3'b001, mp[i], 1'b0);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL load cyc=%0d obs=%h exp=%h", i, obs, exp[i]);
            end
        end
        checks++;
        if (InstrCont !== 2'd1) begin
            failures++;
            $display("FAIL load_count got=%0d exp=1", InstrCont);
        end
    endtask

    task automatic test_store();
        logic        mp  [6];
        logic [15:0] exp [6];
        mp  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp = '{E_BUSCA, E_OCU, E_OCU, E_ESCM | E_SEL | E_OCU, E_ESCM | E_SEL | E_OCU, E_BUSCA};
        doReset();
        for (int i = 0; i < 6; i++) begin
            step(3'b010, mp[i], 1'b0);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL store cyc=%0d obs=%h exp=%h", i, obs, exp[i]);
            end
        end
        checks++;
        if (InstrCont !== 2'd1) begin
            failures++;
            $display("FAIL store_count got=%0d exp=1", InstrCont);
        end
    endtask

    // Jump, taken branch, not-taken branch back to back
    task automatic test_jump_branch();
        logic [2:0]  op  [10];
        logic        z   [10];
        logic [15:0] exp [10];
        op  = '{3'b101, 3'b101, 3'b101, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b000};
        z   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp = '{E_BUSCA, E_OCU, E_JI | E_PC | E_OCU,
                E_BUSCA, E_OCU, E_BQ | E_PC | E_OCU,
                E_BUSCA, E_OCU, E_BQ | E_OCU, E_BUSCA};
        doReset();
        for (int i = 0; i < 10; i++) begin
            step(op[i], 1'b1, z[i]);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL jump_branch cyc=%0d obs=%h exp=%h", i, obs, exp[i]);
            end
        end
        checks++;
        if (InstrCont !== 2'd3) begin
            failures++;
            $display("FAIL jump_branch_count got=%0d exp=3", InstrCont);
        end
    endtask

    task automatic test_timeout();
        doReset();
        // ready on the 4th BUSCA cycle still completes
        for (int i = 0; i < 4; i++) begin
            step(3'b000, (i == 3), 1'b0);
            checks++;
            if (obs !== ((i == 3) ? E_BUSCA : (E_LER | E_OCU))) begin
                failures++;
                $display("FAIL busca_wait cyc=%0d obs=%h", i, obs);
            end
        end
        step(3'b000, 1'b1, 1'b0);
        checks++;
        if (obs !== E_OCU) begin
            failures++;
            $display("FAIL busca_late_ready obs=%h exp=%h", obs, E_OCU);
        end
        step(3'b000, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(3'b000, 1'b0, 1'b0);
            checks++;
            if (obs !== (E_LER | E_OCU)) begin
                failures++;
                $display("FAIL timeout_wait cyc=%0d obs=%h exp=%h", i, obs, E_LER | E_OCU);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(3'b000, (i == 1), 1'b0);
            checks++;
            if (obs !== E_ERRO) begin
                failures++;
                $display("FAIL timeout_erro cyc=%0d obs=%h exp=%h", i, obs, E_ERRO);
            end
        end
        doReset();
        checks++;
        if (obs !== 16'h0000) begin
            failures++;
            $display("FAIL erro_reset obs=%h exp=%h", obs, 16'h0000);
        end
    endtask

    task automatic test_halt();
        doReset();
        step(3'b111, 1'b1, 1'b0);
        step(3'b111, 1'b1, 1'b0);
        checks++;
        if (obs !== E_OCU) begin
            failures++;
            $display("FAIL halt_decod obs=%h exp=%h", obs, E_OCU);
        end
        for (int i = 0; i < 4; i++) begin
            step((i == 3) ? 3'b000 : 3'b111, i[0], 1'b1);
            checks++;
            if (obs !== E_PAR || InstrCont !== 2'd1) begin
                failures++;
                $display("FAIL halt_parado cyc=%0d obs=%h exp=%h cnt=%0d exp=1", i, obs, E_PAR, InstrCont);
            end
        end
    endtask

    // Reset asserted in a store's MEM cycle beats the completing access
    task automatic test_reset_mid_store();
        doReset();
        step(3'b010, 1'b1, 1'b0);
        step(3'b010, 1'b1, 1'b0);
        step(3'b010, 1'b1, 1'b0);
        step(3'b010, 1'b0, 1'b0);
        checks++;
        if (obs !== (E_ESCM | E_SEL | E_OCU)) begin
            failures++;
            $display("FAIL mid_store_mem obs=%h exp=%h", obs, E_ESCM | E_SEL | E_OCU);
        end
        Reset     = 1'b1;
        MemPronta = 1'b1;
        step(3'b010, 1'b1, 1'b0);
        Reset = 1'b0;
        #1;
        checks++;
        if (obs !== 16'h0000 || InstrCont !== 2'd0) begin
            failures++;
            $display("FAIL mid_store_reset obs=%h exp=%h cnt=%0d exp=0", obs, 16'h0000, InstrCont);
        end
    endtask

    // Seven ALU instructions on a 2-bit counter saturate at 3
    task automatic test_saturation();
        doReset();
        for (int k = 0; k < 7; k++) begin
            for (int c = 0; c < 4; c++) step(3'b000, 1'b1, 1'b0);
            checks++;
            if (obs !== (E_OP10 | E_REG | E_OCU)) begin
                failures++;
                $display("FAIL sat_escrita k=%0d obs=%h exp=%h", k, obs, E_OP10 | E_REG | E_OCU);
            end
        end
        step(3'b000, 1'b1, 1'b0);
        checks++;
        if (InstrCont !== 2'd3) begin
            failures++;
            $display("FAIL sat_count got=%0d exp=3", InstrCont);
        end
    endtask

    initial begin
        Reset     = 1'b1;
        Opcode    = 3'b000;
        Zero      = 1'b0;
        MemPronta = 1'b0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_jump_branch();
        test_timeout();
        test_halt();
        test_reset_mid_store();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
